// File: rtl/pair_seq_tx_pkg.sv
// pair_seq_tx_pkg: shared state encodings and defaults for the pair transmitter and its tracker.
package pair_seq_tx_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} tx_state_t;
    // Same encoding as the receive-side detector so traces line up.
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} trk_state_t;
endpackage

// File: rtl/pair_seq_tx_if.sv
// pair_seq_tx_if: word handshake plus framed serial stream and per-frame pair count.
interface pair_seq_tx_if
    import pair_seq_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH / 2 + 1)
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             done;
    logic [CNT_W-1:0] pair_cnt;
    modport slave  (input in_valid, in_data,
                    output in_ready, ser_out, ser_valid, ser_first, ser_last, done, pair_cnt);
    modport master (output in_valid, in_data,
                    input in_ready, ser_out, ser_valid, ser_first, ser_last, done, pair_cnt);
endinterface

// File: rtl/pair_seq_tx_pair_track.sv
// pair_track: Mealy consecutive-equal-pair (00/11) rule, non-overlapping, with synchronous clear.
module pair_track
    import pair_seq_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic match
);
    trk_state_t r_st, w_nxt;
    always_comb begin
        w_nxt = r_st;
        match = 1'b0;
        if (bit_valid) begin
            match = (r_st == S1 && bit_in) || (r_st == S2 && !bit_in);
            w_nxt = match ? S0 : (bit_in ? S1 : S2);
        end
        // Clear wins so the next frame's first bit is seen from S0.
        if (clr) w_nxt = S0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= S0;
        else        r_st <= w_nxt;
    end
endmodule

// File: rtl/pair_seq_tx.sv
// pair_seq_tx: serialises words MSB first with frame markers and reports the
// per-frame pair-match count a freshly reset detector would produce.
module pair_seq_tx
    import pair_seq_tx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH / 2 + 1)
)
(
    input  logic          clk,
    input  logic          rst_n,
    pair_seq_tx_if.slave  bus
);
    localparam int K_W = $clog2(WIDTH);
    tx_state_t        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [K_W-1:0]   r_k;
    logic             r_valid, r_first, r_last, r_done;
    logic [CNT_W-1:0] r_cnt, r_pair, w_cnt_nxt;
    logic             w_ready, w_hs, w_match;

    always_comb begin
        w_ready     = (r_state == IDLE) || r_last;
        w_hs        = bus.in_valid && w_ready;
        w_state_nxt = w_hs ? SHIFT : (r_last ? IDLE : r_state);
        w_cnt_nxt   = r_cnt + CNT_W'(w_match);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // The shift register doubles as the serial output: its MSB is ser_out and it
    // is zeroed between frames so the idle line reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh    <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_pair  <= '0;
        end else begin
            r_done <= r_last;
            if (r_last) r_pair <= w_cnt_nxt;
            r_cnt <= (w_hs || r_last) ? '0 : w_cnt_nxt;
            if (w_hs) begin
                r_sh    <= bus.in_data;
                r_k     <= '0;
                r_valid <= 1'b1;
                r_first <= 1'b1;
                r_last  <= 1'b0;
            end else if (r_state == SHIFT && !r_last) begin
                r_sh    <= r_sh << 1;
                r_k     <= r_k + 1'b1;
                r_first <= 1'b0;
                r_last  <= (r_k == K_W'(WIDTH - 2));
            end else begin
                r_sh    <= '0;
                r_k     <= '0;
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    pair_track u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_hs),
        .bit_valid (r_valid),
        .bit_in    (r_sh[WIDTH-1]),
        .match     (w_match)
    );

    assign bus.in_ready  = w_ready;
    assign bus.ser_out   = r_sh[WIDTH-1];
    assign bus.ser_valid = r_valid;
    assign bus.ser_first = r_first;
    assign bus.ser_last  = r_last;
    assign bus.done      = r_done;
    assign bus.pair_cnt  = r_pair;
endmodule

// File: tb/tb_pair_seq_tx.sv
// tb_pair_seq_tx: scoreboard bench; the driver queues expected bits and counts,
// a negedge monitor pops and compares every cycle.
module tb_pair_seq_tx;
    localparam int W = 8;
    localparam int CW = $clog2(W / 2 + 1);

    typedef struct {
        logic b;
        logic f;
        logic l;
    } bit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vec = 0;
    int   mis = 0;
    bit_t q_bits[$];
    int   q_cnt[$];
    logic prev_last = 1'b0;
    int   m_pair = 0;

    pair_seq_tx_if #(.WIDTH(W)) bus ();
    pair_seq_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic void chk(input string n, input int a, input int e);
        vec++;
        if (a !== e) begin
            mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endfunction

    // Greedy scan for non-overlapping adjacent equal bits, MSB first.
    function automatic int ref_pairs(input logic [W-1:0] w);
        int c = 0;
        int k = W - 1;
        while (k >= 1) begin
            if (w[k] == w[k-1]) begin
                c++;
                k -= 2;
            end else k -= 1;
        end
        return c;
    endfunction

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_wait", int'(bus.in_ready), 1);
        if (bus.in_ready) begin
            @(posedge clk);
            for (int k = 0; k < W; k++) q_bits.push_back('{w[W-1-k], k == 0, k == W - 1});
            q_cnt.push_back(ref_pairs(w));
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        bit_t e;
        if (!rst_n) begin
            q_bits.delete();
            q_cnt.delete();
            prev_last = 1'b0;
            m_pair = 0;
            chk("rst_ser_valid", int'(bus.ser_valid), 0);
            chk("rst_ser_out", int'(bus.ser_out), 0);
            chk("rst_done", int'(bus.done), 0);
            chk("rst_pair_cnt", int'(bus.pair_cnt), 0);
            chk("rst_in_ready", int'(bus.in_ready), 1);
        end else begin
            chk("in_ready", int'(bus.in_ready), int'(q_bits.size() <= 1));
            chk("done", int'(bus.done), int'(prev_last));
            if (prev_last && q_cnt.size() != 0) m_pair = q_cnt.pop_front();
            chk("pair_cnt", int'(bus.pair_cnt), m_pair);
            if (q_bits.size() != 0) begin
                e = q_bits.pop_front();
                chk("ser_valid", int'(bus.ser_valid), 1);
                chk("ser_out", int'(bus.ser_out), int'(e.b));
                chk("ser_first", int'(bus.ser_first), int'(e.f));
                chk("ser_last", int'(bus.ser_last), int'(e.l));
                prev_last = e.l;
            end else begin
                chk("idle_ser_valid", int'(bus.ser_valid), 0);
                chk("idle_ser_out", int'(bus.ser_out), 0);
                chk("idle_ser_first", int'(bus.ser_first), 0);
                chk("idle_ser_last", int'(bus.ser_last), 0);
                prev_last = 1'b0;
            end
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(10);
        send(8'hB4);
        idle(12);
        send(8'hFF);
        send(8'hAA);
        idle(12);
        send(8'hE7);
        send(8'h33);
        idle(12);
        // Abort a frame mid-flight; its done must never appear.
        send(8'h55);
        idle(5);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        send(8'hFF);
        idle(12);
        for (int i = 0; i < 200; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(1);
        n = 0;
        while ((q_bits.size() != 0 || prev_last) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q_bits.size(), 0);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
